instruction_decode: RTL and testbench

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/instruction_decode_pkg.sv | 33 +++
 rtl/instruction_decode_regfile.sv | 45 ++++
 rtl/instruction_decode.sv | 246 ++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared RV32I decode constants: opcodes, ctrl bit positions, NOP and bubble PC.
package instruction_decode_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned C_REG_WRITE = 9;
    localparam int unsigned C_MEM_READ  = 8;
    localparam int unsigned C_MEM_WRITE = 7;
    localparam int unsigned C_BRANCH    = 6;
    localparam int unsigned C_JAL       = 5;
    localparam int unsigned C_JALR      = 4;
    localparam int unsigned C_LUI       = 3;
    localparam int unsigned C_AUIPC     = 2;
    localparam int unsigned C_ALU_IMM   = 1;
    localparam int unsigned C_SUB_SRA   = 0;

    localparam logic [31:0] INSTR_NOP = 32'h00000013;
    localparam logic [31:0] BUBBLE_PC = 32'hDEADC0DE;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/instruction_decode_regfile.sv
// Register file: 2 async read ports, 1 sync write port, x0 hard-wired to zero.
// Optional same-cycle writeback bypass under DECODE_WB_BYPASS_EN.
module register_file
    import instruction_decode_pkg::*;
#(
    parameter int unsigned REGS = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] regs_q [REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef DECODE_WB_BYPASS_EN
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: decoder, load-use hazard detect and ID/EX register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback into the read ports.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int unsigned REGS = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     instr_if_i,
    input  logic [31:0]     pc_if_i,
    input  logic            pred_taken_if_i,
    input  logic [31:0]     btb_pc_if_i,
    input  logic            branching_i,
    input  logic            periheral_stall_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            load_stall_o,
    output logic [XLEN-1:0] rs1_data_id_o,
    output logic [XLEN-1:0] rs2_data_id_o,
    output logic [31:0]     imm_id_o,
    output logic [4:0]      rs1_id_o,
    output logic [4:0]      rs2_id_o,
    output logic [4:0]      rd_id_o,
    output logic [2:0]      funct3_id_o,
    output logic [9:0]      ctrl_id_o,
    output logic [31:0]     pc_id_o,
    output logic            pred_taken_id_o,
    output logic [31:0]     btb_pc_id_o
);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [31:0]     pc;
        logic            pred_taken;
        logic [31:0]     btb_pc;
    } id_ex_t;

    logic [6:0]  opc;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opc   = instr_if_i[6:0];
    assign f_rd  = instr_if_i[11:7];
    assign f3    = instr_if_i[14:12];
    assign f_rs1 = instr_if_i[19:15];
    assign f_rs2 = instr_if_i[24:20];

    assign imm_i = {{20{instr_if_i[31]}}, instr_if_i[31:20]};
    assign imm_s = {{20{instr_if_i[31]}}, instr_if_i[31:25], instr_if_i[11:7]};
    assign imm_b = {{19{instr_if_i[31]}}, instr_if_i[31], instr_if_i[7],
                    instr_if_i[30:25], instr_if_i[11:8], 1'b0};
    assign imm_u = {instr_if_i[31:12], 12'b0};
    assign imm_j = {{11{instr_if_i[31]}}, instr_if_i[31], instr_if_i[19:12],
                    instr_if_i[20], instr_if_i[30:21], 1'b0};

    ctrl_t       dec_ctrl;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_f3;

    // Unused source fields stay zero so the hazard compare needs no format info.
    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        dec_rd   = '0;
        dec_rs1  = '0;
        dec_rs2  = '0;
        dec_f3   = '0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_SUB_SRA]   = instr_if_i[30] &&
                                        ((f3 == 3'b000) || (f3 == 3'b101));
                dec_rd  = f_rd;
                dec_rs1 = f_rs1;
                dec_rs2 = f_rs2;
                dec_f3  = f3;
            end
            (opc == OPC_OPIMM): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_ctrl[C_SUB_SRA]   = instr_if_i[30] && (f3 == 3'b101);
                dec_imm = imm_i;
                dec_rd  = f_rd;
                dec_rs1 = f_rs1;
                dec_f3  = f3;
            end
            (opc == OPC_LOAD): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_MEM_READ]  = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_imm = imm_i;
                dec_rd  = f_rd;
                dec_rs1 = f_rs1;
                dec_f3  = f3;
            end
            (opc == OPC_STORE): begin
                dec_ctrl[C_MEM_WRITE] = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_imm = imm_s;
                dec_rs1 = f_rs1;
                dec_rs2 = f_rs2;
                dec_f3  = f3;
            end
            (opc == OPC_BRANCH): begin
                dec_ctrl[C_BRANCH] = 1'b1;
                dec_imm = imm_b;
                dec_rs1 = f_rs1;
                dec_rs2 = f_rs2;
                dec_f3  = f3;
            end
            (opc == OPC_JAL): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_JAL]       = 1'b1;
                dec_imm = imm_j;
                dec_rd  = f_rd;
            end
            (opc == OPC_JALR): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_JALR]      = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_imm = imm_i;
                dec_rd  = f_rd;
                dec_rs1 = f_rs1;
                dec_f3  = f3;
            end
            (opc == OPC_LUI): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_LUI]       = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_imm = imm_u;
                dec_rd  = f_rd;
            end
            (opc == OPC_AUIPC): begin
                dec_ctrl[C_REG_WRITE] = 1'b1;
                dec_ctrl[C_AUIPC]     = 1'b1;
                dec_ctrl[C_ALU_IMM]   = 1'b1;
                dec_imm = imm_u;
                dec_rd  = f_rd;
            end
            default: begin
                dec_ctrl = '0;
            end
        endcase
    end

    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    register_file #(
        .REGS (REGS),
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .raddr1_i (dec_rs1),
        .raddr2_i (dec_rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i)
    );

    id_ex_t ex_q;
    id_ex_t ex_d;
    id_ex_t bubble;
    id_ex_t capture;
    logic   load_stall;

    assign load_stall = ex_q.ctrl[C_MEM_READ] && (ex_q.rd != '0) &&
                        ((ex_q.rd == dec_rs1) || (ex_q.rd == dec_rs2));

    always_comb begin
        bubble    = '0;
        bubble.pc = BUBBLE_PC;
    end

    always_comb begin
        capture            = '0;
        capture.ctrl       = dec_ctrl;
        capture.rd         = dec_rd;
        capture.rs1        = dec_rs1;
        capture.rs2        = dec_rs2;
        capture.funct3     = dec_f3;
        capture.imm        = dec_imm;
        capture.rs1_data   = rf_rdata1;
        capture.rs2_data   = rf_rdata2;
        capture.pc         = pc_if_i;
        capture.pred_taken = pred_taken_if_i;
        capture.btb_pc     = btb_pc_if_i;
    end

    // A redirect always wins, even over a peripheral hold.
    always_comb begin
        ex_d = capture;
        if (branching_i) begin
            ex_d = bubble;
        end else if (periheral_stall_i) begin
            ex_d = ex_q;
        end else if (load_stall) begin
            ex_d = bubble;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign load_stall_o    = load_stall;
    assign rs1_data_id_o   = ex_q.rs1_data;
    assign rs2_data_id_o   = ex_q.rs2_data;
    assign imm_id_o        = ex_q.imm;
    assign rs1_id_o        = ex_q.rs1;
    assign rs2_id_o        = ex_q.rs2;
    assign rd_id_o         = ex_q.rd;
    assign funct3_id_o     = ex_q.funct3;
    assign ctrl_id_o       = ex_q.ctrl;
    assign pc_id_o         = ex_q.pc;
    assign pred_taken_id_o = ex_q.pred_taken;
    assign btb_pc_id_o     = ex_q.btb_pc;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_if_i;
    logic [31:0] pc_if_i;
    logic        pred_taken_if_i;
    logic [31:0] btb_pc_if_i;
    logic        branching_i;
    logic        periheral_stall_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        load_stall_o;
    logic [31:0] rs1_data_id_o;
    logic [31:0] rs2_data_id_o;
    logic [31:0] imm_id_o;
    logic [4:0]  rs1_id_o;
    logic [4:0]  rs2_id_o;
    logic [4:0]  rd_id_o;
    logic [2:0]  funct3_id_o;
    logic [9:0]  ctrl_id_o;
    logic [31:0] pc_id_o;
    logic        pred_taken_id_o;
    logic [31:0] btb_pc_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .instr_if_i        (instr_if_i),
        .pc_if_i           (pc_if_i),
        .pred_taken_if_i   (pred_taken_if_i),
        .btb_pc_if_i       (btb_pc_if_i),
        .branching_i       (branching_i),
        .periheral_stall_i (periheral_stall_i),
        .wb_we_i           (wb_we_i),
        .wb_rd_i           (wb_rd_i),
        .wb_data_i         (wb_data_i),
        .load_stall_o      (load_stall_o),
        .rs1_data_id_o     (rs1_data_id_o),
        .rs2_data_id_o     (rs2_data_id_o),
        .imm_id_o          (imm_id_o),
        .rs1_id_o          (rs1_id_o),
        .rs2_id_o          (rs2_id_o),
        .rd_id_o           (rd_id_o),
        .funct3_id_o       (funct3_id_o),
        .ctrl_id_o         (ctrl_id_o),
        .pc_id_o           (pc_id_o),
        .pred_taken_id_o   (pred_taken_id_o),
        .btb_pc_id_o       (btb_pc_id_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[6];

    localparam logic [31:0] ADDI = 32'hFFD08113;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] ADD  = 32'h00528333;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] DEAD = 32'hDEADC0DE;

    initial begin
        vecs[0] = '{32'h402081B3, 10'h201, 32'h00000000, 5'd3, 5'd1, 5'd2};
        vecs[1] = '{32'h0020A423, 10'h082, 32'h00000008, 5'd0, 5'd1, 5'd2};
        vecs[2] = '{32'hFE208EE3, 10'h040, 32'hFFFFFFFC, 5'd0, 5'd1, 5'd2};
        vecs[3] = '{32'h008000EF, 10'h220, 32'h00000008, 5'd1, 5'd0, 5'd0};
        vecs[4] = '{32'h123452B7, 10'h20A, 32'h12345000, 5'd5, 5'd0, 5'd0};
        vecs[5] = '{32'h0000007F, 10'h000, 32'h00000000, 5'd0, 5'd0, 5'd0};

        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_if_i        = $urandom;
            pc_if_i           = $urandom;
            pred_taken_if_i   = 1'($urandom);
            btb_pc_if_i       = $urandom;
            branching_i       = 1'($urandom);
            periheral_stall_i = 1'($urandom);
            wb_we_i           = 1'($urandom);
            wb_rd_i           = 5'($urandom);
            wb_data_i         = $urandom;
            tick();
            check("rst_ctrl", 32'(ctrl_id_o), 32'h0);
            check("rst_pc", pc_id_o, 32'h0);
            check("rst_stall", 32'(load_stall_o), 32'h0);
        end
        check("rst_imm", imm_id_o, 32'h0);
        check("rst_rs1d", rs1_data_id_o, 32'h0);
        check("rst_btb", btb_pc_id_o, 32'h0);

        instr_if_i        = NOP;
        pc_if_i           = 32'h0;
        pred_taken_if_i   = 1'b0;
        btb_pc_if_i       = 32'h0;
        branching_i       = 1'b0;
        periheral_stall_i = 1'b0;
        wb_we_i           = 1'b0;
        wb_rd_i           = 5'd0;
        wb_data_i         = 32'h0;
        rst_ni            = 1'b1;

        wb_we_i   = 1'b1;
        wb_rd_i   = 5'd1;
        wb_data_i = 32'd5;
        tick();
        wb_we_i = 1'b0;

        instr_if_i      = ADDI;
        pc_if_i         = 32'h100;
        pred_taken_if_i = 1'b1;
        btb_pc_if_i     = 32'h200;
        tick();
        check("addi_imm", imm_id_o, 32'hFFFFFFFD);
        check("addi_rs1d", rs1_data_id_o, 32'd5);
        check("addi_rd", 32'(rd_id_o), 32'd2);
        check("addi_ctrl", 32'(ctrl_id_o), 32'h202);
        check("addi_pc", pc_id_o, 32'h100);
        check("addi_pred", 32'(pred_taken_id_o), 32'h1);
        check("addi_btb", btb_pc_id_o, 32'h200);
        check("addi_rs2", 32'(rs2_id_o), 32'h0);
        pred_taken_if_i = 1'b0;
        btb_pc_if_i     = 32'h0;

        for (int i = 0; i < 6; i++) begin
            instr_if_i = vecs[i].instr;
            pc_if_i    = 32'h1000 + 32'(i * 4);
            tick();
            check($sformatf("v%0d_ctrl", i), 32'(ctrl_id_o), 32'(vecs[i].ctrl));
            check($sformatf("v%0d_imm", i), imm_id_o, vecs[i].imm);
            check($sformatf("v%0d_rd", i), 32'(rd_id_o), 32'(vecs[i].rd));
            check($sformatf("v%0d_rs1", i), 32'(rs1_id_o), 32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i), 32'(rs2_id_o), 32'(vecs[i].rs2));
        end

        instr_if_i = LW;
        pc_if_i    = 32'h200;
        tick();
        check("lw_ctrl", 32'(ctrl_id_o), 32'h302);
        instr_if_i = ADD;
        pc_if_i    = 32'h204;
        #1;
        check("lu_stall", 32'(load_stall_o), 32'h1);
        tick();
        check("lu_bub_ctrl", 32'(ctrl_id_o), 32'h0);
        check("lu_bub_pc", pc_id_o, DEAD);
        check("lu_bub_rd", 32'(rd_id_o), 32'h0);
        check("lu_bub_rs1d", rs1_data_id_o, 32'h0);
        check("lu_stall_gone", 32'(load_stall_o), 32'h0);
        tick();
        check("lu_add_ctrl", 32'(ctrl_id_o), 32'h200);
        check("lu_add_rd", 32'(rd_id_o), 32'd6);
        check("lu_add_pc", pc_id_o, 32'h204);

        instr_if_i = LW;
        tick();
        instr_if_i  = ADD;
        branching_i = 1'b1;
        #1;
        check("br_haz_stall", 32'(load_stall_o), 32'h1);
        tick();
        check("br_haz_ctrl", 32'(ctrl_id_o), 32'h0);
        check("br_haz_pc", pc_id_o, DEAD);

        instr_if_i      = ADDI;
        pc_if_i         = 32'h500;
        pred_taken_if_i = 1'b1;
        btb_pc_if_i     = 32'h600;
        branching_i     = 1'b1;
        tick();
        check("fl_ctrl", 32'(ctrl_id_o), 32'h0);
        check("fl_pc", pc_id_o, DEAD);
        check("fl_pred", 32'(pred_taken_id_o), 32'h0);
        check("fl_btb", btb_pc_id_o, 32'h0);
        branching_i = 1'b0;

        pc_if_i = 32'h300;
        tick();
        periheral_stall_i = 1'b1;
        instr_if_i        = ADD;
        pc_if_i           = 32'h400;
        pred_taken_if_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_pc", i), pc_id_o, 32'h300);
            check($sformatf("hold%0d_ctrl", i), 32'(ctrl_id_o), 32'h202);
            check($sformatf("hold%0d_imm", i), imm_id_o, 32'hFFFFFFFD);
            check($sformatf("hold%0d_rs1d", i), rs1_data_id_o, 32'd5);
        end
        periheral_stall_i = 1'b0;
        tick();
        check("hold_rel_pc", pc_id_o, 32'h400);

        wb_we_i   = 1'b1;
        wb_rd_i   = 5'd7;
        wb_data_i = 32'h11111111;
        tick();
        instr_if_i = 32'h00038413;
        wb_data_i  = 32'hA5A5A5A5;
        tick();
`ifdef DECODE_WB_BYPASS_EN
        check("byp_rs1d", rs1_data_id_o, 32'hA5A5A5A5);
`else
        check("byp_rs1d", rs1_data_id_o, 32'h11111111);
`endif
        wb_we_i = 1'b0;
        tick();
        check("byp_after", rs1_data_id_o, 32'hA5A5A5A5);
        wb_we_i    = 1'b1;
        wb_rd_i    = 5'd0;
        wb_data_i  = 32'hFFFFFFFF;
        instr_if_i = 32'h00000493;
        tick();
        check("x0_same", rs1_data_id_o, 32'h0);
        wb_we_i = 1'b0;
        tick();
        check("x0_after", rs1_data_id_o, 32'h0);

        instr_if_i = LW;
        tick();
        instr_if_i = ADD;
        #1;
        check("mr_stall_pre", 32'(load_stall_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("mr_ctrl", 32'(ctrl_id_o), 32'h0);
        check("mr_pc", pc_id_o, 32'h0);
        check("mr_stall", 32'(load_stall_o), 32'h0);
        #3;
        rst_ni     = 1'b1;
        instr_if_i = ADDI;
        pc_if_i    = 32'h700;
        tick();
        check("mr_cap_pc", pc_id_o, 32'h700);
        check("mr_cap_rd", 32'(rd_id_o), 32'd2);
        check("mr_x1_clr", rs1_data_id_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
